// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    TX_WAIT,
    TX_SHIFT,
    HOLD
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // A frame is the two command bits followed by one payload word.
  function automatic int unsigned frame_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Shifts a loaded read word out on MISO, MSB first, one bit per clock.
module spi_tx_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_miso,
  output logic              o_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_miso <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= CNT_FULL;
      r_miso  <= 1'b0;
    end else if (r_cnt != '0) begin
      r_miso  <= r_shift[DATA_W-1];
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt - 1'b1;
    end else begin
      r_miso <= 1'b0;
    end
  end

  // High in the cycle whose clock edge drives the final bit.
  assign o_done = (r_cnt == CNT_ONE);
  assign o_miso = r_miso;

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave: deserialises {cmd, payload} frames to the RAM and serialises read data onto MISO.
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BURST      = 0,
  parameter int unsigned TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned FRAME_W = frame_w(DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned TMO_W   = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

  spi_state_e         r_state;
  logic [FRAME_W-2:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_rd_addr_done;

  spi_state_e w_end_state;
  logic       w_ser_load;
  logic       w_ser_done;
  logic       w_mid_frame;

  // SS_n is known to be low wherever the frame-end target is taken.
  assign w_end_state = (BURST != 0) ? CHK_CMD : HOLD;
  assign w_ser_load  = (r_state == TX_WAIT) && !SS_n && tx_valid;
  assign w_mid_frame = (r_bit_cnt != '0) || (r_state == TX_WAIT) || (r_state == TX_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_tmo_cnt      <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_rd_addr_done <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (SS_n) begin
        if (r_state != IDLE) begin
          r_state     <= IDLE;
          r_bit_cnt   <= '0;
          r_tmo_cnt   <= '0;
          r_frame_err <= w_mid_frame;
        end
      end else begin
        unique case (r_state)
          IDLE: r_state <= CHK_CMD;
          CHK_CMD: begin
            if (!MOSI)               r_state <= WRITE;
            else if (r_rd_addr_done) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            r_shift <= {r_shift[FRAME_W-3:0], MOSI};
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt  <= '0;
              r_rx_data  <= {r_shift, MOSI};
              r_rx_valid <= 1'b1;
              if (r_state == READ_DATA) begin
                r_state <= TX_WAIT;
              end else begin
                if (r_state == READ_ADD) r_rd_addr_done <= 1'b1;
                r_state <= w_end_state;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          TX_WAIT: begin
            if (tx_valid) begin
              r_tmo_cnt <= '0;
              r_state   <= TX_SHIFT;
            end else if (r_tmo_cnt == TMO_LAST) begin
              r_tmo_cnt   <= '0;
              r_frame_err <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
          TX_SHIFT: begin
            if (w_ser_done) begin
              r_rd_addr_done <= 1'b0;
              r_state        <= w_end_state;
            end
          end
          HOLD:    r_state <= HOLD;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ser_load),
    .i_data  (tx_data),
    .i_clear (SS_n),
    .o_miso  (MISO),
    .o_done  (w_ser_done)
  );

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_gen.sv
// Randomised self-checking bench for spi_slave_gen against a transaction-level frame model.
module tb_spi_slave_gen;
  import spi_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned FW  = DW + 2;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n, ss_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;
  logic          miso, rx_valid, frame_err, busy;
  logic [FW-1:0] rx_data;

  logic          b_ss_n, b_mosi, b_tx_valid;
  logic [DW-1:0] b_tx_data;
  logic          b_miso, b_rx_valid, b_frame_err, b_busy;
  logic [FW-1:0] b_rx_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: whether a read address is pending, and the last delivered frame.
  bit            m_rd_addr_done;
  logic [FW-1:0] m_rx_data;

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(DW), .BURST(0), .TX_TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  spi_slave_gen #(.DATA_W(DW), .BURST(1), .TX_TIMEOUT(TMO)) u_dut_burst (
    .clk(clk), .rst_n(rst_n), .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(b_miso),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .frame_err(b_frame_err), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxd"}, 32'(rx_data), 32'(0));
    check({tag, "_rxv"}, 32'(rx_valid), 32'(0));
    check({tag, "_err"}, 32'(frame_err), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_miso"}, 32'(miso), 32'(0));
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic reset_now();
    #2 rst_n = 1'b0;
    ss_n = 1'b1; tx_valid = 1'b0; mosi = 1'b0;
    #1 check_all_zero("async_rst");
    m_rd_addr_done = 1'b0;
    m_rx_data      = '0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Starts a frame and shifts in the first n bits without completing it.
  task automatic send_partial(input bit sel, input logic [FW-1:0] frm, input int n);
    ss_n = 1'b0; tick();
    mosi = sel;  tick();
    for (int i = 0; i < n; i++) begin
      mosi = frm[FW-1-i];
      tick();
    end
  endtask

  // One complete transaction; negative abort/timing arguments mean "not used".
  task automatic run_frame(input bit sel, input logic [FW-1:0] frm, input int abort_at,
                           input int wait_abort, input int tx_delay, input int tx_abort,
                           input logic [DW-1:0] word);
    bit is_rd_data;
    bit captured;
    is_rd_data = sel && m_rd_addr_done;
    ss_n = 1'b0; tick();
    check("busy_start", 32'(busy), 32'(1));
    mosi = sel; tick();
    check("sel_quiet", 32'({rx_valid, frame_err}), 32'(0));
    for (int i = 0; i < int'(FW); i++) begin
      if (i == abort_at) begin
        ss_n = 1'b1; tick();
        check("abort_err", 32'(frame_err), 32'(i > 0));
        check("abort_rxv", 32'(rx_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_rxd", 32'(rx_data), 32'(m_rx_data));
        tick();
        check("abort_pulse", 32'(frame_err), 32'(0));
        return;
      end
      mosi     = frm[FW-1-i];
      tx_valid = 1'($urandom);
      tx_data  = DW'($urandom);
      tick();
      check("rx_valid", 32'(rx_valid), 32'(i == int'(FW) - 1));
    end
    tx_valid  = 1'b0;
    m_rx_data = frm;
    check("rx_data", 32'(rx_data), 32'(m_rx_data));
    check("frame_ok", 32'(frame_err), 32'(0));

    if (!is_rd_data) begin
      if (sel) m_rd_addr_done = 1'b1;
      // A stray tx_valid here must not start a transmission.
      tx_valid = 1'b1;
      tx_data  = 8'h80 | DW'($urandom);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("hold_rxv", 32'(rx_valid), 32'(0));
        check("hold_miso", 32'(miso), 32'(0));
        check("hold_busy", 32'(busy), 32'(1));
        check("hold_err", 32'(frame_err), 32'(0));
      end
      tx_valid = 1'b0;
    end else begin
      captured = 1'b0;
      for (int c = 0; c < int'(TMO) && !captured; c++) begin
        if (c == wait_abort) begin
          ss_n = 1'b1; tick();
          check("wait_abort_err", 32'(frame_err), 32'(1));
          check("wait_abort_busy", 32'(busy), 32'(0));
          check("wait_abort_miso", 32'(miso), 32'(0));
          tick();
          return;
        end
        if (c == tx_delay) begin
          tx_valid = 1'b1;
          tx_data  = word;
        end
        tick();
        tx_valid = 1'b0;
        check("wait_rxv", 32'(rx_valid), 32'(0));
        check("wait_miso", 32'(miso), 32'(0));
        if (c == tx_delay) captured = 1'b1;
        else check("tmo_err", 32'(frame_err), 32'(c == int'(TMO) - 1));
      end
      if (!captured) begin
        tick();
        check("tmo_pulse", 32'(frame_err), 32'(0));
        check("tmo_hold", 32'(busy), 32'(1));
      end else begin
        for (int b = 0; b < int'(DW); b++) begin
          if (b == tx_abort) begin
            ss_n = 1'b1; tick();
            check("shift_abort_err", 32'(frame_err), 32'(1));
            check("shift_abort_miso", 32'(miso), 32'(0));
            check("shift_abort_busy", 32'(busy), 32'(0));
            tick();
            return;
          end
          tick();
          check("miso_bit", 32'(miso), 32'(word[DW-1-b]));
          check("shift_err", 32'(frame_err), 32'(0));
        end
        m_rd_addr_done = 1'b0;
        tick();
        check("miso_idle", 32'(miso), 32'(0));
        check("post_tx_busy", 32'(busy), 32'(1));
      end
    end
    ss_n = 1'b1; tick();
    check("end_busy", 32'(busy), 32'(0));
    check("end_err", 32'(frame_err), 32'(0));
  endtask

  // Two write frames back to back with SS_n held low on the BURST=1 instance.
  task automatic burst_pair();
    logic [FW-1:0] frm;
    b_ss_n = 1'b0; tick();
    for (int f = 0; f < 2; f++) begin
      frm = (f == 0) ? {CMD_WR_ADDR, 8'hA5} : {CMD_WR_DATA, 8'h55};
      b_mosi = 1'b0; tick();
      check("b_busy_sel", 32'(b_busy), 32'(1));
      for (int i = 0; i < int'(FW); i++) begin
        b_mosi = frm[FW-1-i];
        tick();
        check("b_rx_valid", 32'(b_rx_valid), 32'(i == int'(FW) - 1));
        check("b_busy", 32'(b_busy), 32'(1));
      end
      check("b_rx_data", 32'(b_rx_data), 32'(frm));
      check("b_err", 32'(b_frame_err), 32'(0));
    end
    b_ss_n = 1'b1; tick();
    check("b_end_busy", 32'(b_busy), 32'(0));
    check("b_end_err", 32'(b_frame_err), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, busy=%0b", busy);
    $fatal(1);
  end

  initial begin
    bit            sel;
    logic [FW-1:0] frm;
    int            abort_at, wait_abort, tx_delay, tx_abort, r;

    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    b_ss_n = 1'b1; b_mosi = 1'b0; b_tx_valid = 1'b0; b_tx_data = '0;
    m_rd_addr_done = 1'b0;
    m_rx_data      = '0;
    #3 check_all_zero("reset");
    #4 rst_n = 1'b1;
    tick();

    // Directed cases.
    run_frame(1'b0, {CMD_WR_ADDR, 8'hA5}, -1, -1, 0, -1, '0);
    run_frame(1'b1, {CMD_RD_ADDR, 8'h03}, -1, -1, 0, -1, '0);
    run_frame(1'b1, {CMD_RD_DATA, 8'h00}, -1, -1, 2, -1, 8'hC3);
    run_frame(1'b0, {CMD_WR_DATA, 8'h3C}, 5, -1, 0, -1, '0);
    run_frame(1'b0, {CMD_WR_DATA, 8'h3C}, int'(FW) - 1, -1, 0, -1, '0);
    run_frame(1'b0, {CMD_WR_DATA, 8'h3C}, 0, -1, 0, -1, '0);
    run_frame(1'b1, {CMD_RD_ADDR, 8'h11}, -1, -1, 0, -1, '0);
    run_frame(1'b1, {CMD_RD_DATA, 8'h00}, -1, -1, int'(TMO), -1, 8'hFF);
    run_frame(1'b1, {CMD_RD_DATA, 8'h00}, -1, -1, int'(TMO) - 1, -1, 8'h81);
    burst_pair();

    // Reset in the middle of a read-address frame and of a transmission.
    send_partial(1'b1, {CMD_RD_ADDR, 8'h5A}, 4);
    reset_now();
    run_frame(1'b1, {CMD_RD_ADDR, 8'h22}, -1, -1, 0, -1, '0);
    send_partial(1'b1, {CMD_RD_DATA, 8'h00}, int'(FW));
    tx_valid = 1'b1; tx_data = 8'hFF; tick();
    tx_valid = 1'b0; tick(); tick();
    check("pre_rst_miso", 32'(miso), 32'(1));
    reset_now();
    run_frame(1'b1, {CMD_RD_ADDR, 8'h33}, -1, -1, 0, -1, '0);

    for (int n = 0; n < 150; n++) begin
      sel        = 1'($urandom);
      frm        = FW'($urandom);
      abort_at   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FW - 1)) : -1;
      wait_abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TMO - 1)) : -1;
      tx_abort   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
      r          = int'($urandom_range(0, 9));
      tx_delay   = (r < 7) ? int'($urandom_range(0, 3)) : (r == 7) ? int'(TMO) - 1 : int'(TMO);
      run_frame(sel, frm, abort_at, wait_abort, tx_delay, tx_abort, DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
